dmem_responder: RTL

- Memory-side responder for the pipelined core's data port (mem_we, mem_data_addr, mem_write_data -> mem_read_data).
- Serves a word-addressed data RAM plus a small MMIO window: free-running cycle counter, status/clear registers, and an output FIFO drained by a host over valid/ready.
- Reads are combinational, because the core consumes read data in the same M-stage cycle. Writes commit on the clock edge.

---
 rtl/mips_mmio_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/dmem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared MMIO constants, status bit positions and region decode for the data-port responder.
package mips_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [15:0] OFF_CYCLE      = 16'h0000;
  localparam logic [15:0] OFF_FIFO_DATA  = 16'h0004;
  localparam logic [15:0] OFF_STATUS     = 16'h0008;
  localparam logic [15:0] OFF_STATUS_CLR = 16'h000C;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_MISALIGN  = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_CYCLE,
    SEL_FIFO,
    SEL_STATUS,
    SEL_CLR,
    SEL_NONE
  } mmio_sel_t;

  // Offsets must match exactly, so unaligned MMIO reads land in SEL_NONE and return 0.
  function automatic mmio_sel_t decode_sel(input logic [31:0] addr, input logic [15:0] base_hi);
    mmio_sel_t sel;
    sel = SEL_NONE;
    if (addr[31:16] != base_hi) begin
      sel = SEL_RAM;
    end else begin
      case (addr[15:0])
        OFF_CYCLE:      sel = SEL_CYCLE;
        OFF_FIFO_DATA:  sel = SEL_FIFO;
        OFF_STATUS:     sel = SEL_STATUS;
        OFF_STATUS_CLR: sel = SEL_CLR;
        default:        sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head is visible the cycle after the push edge (no bypass).
// Latency: 1 cycle push-to-head. Backpressure: push while full is dropped and flagged on overflow_pulse.
// Full/empty come from the pre-edge count, so a pop does not make room for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty          = (count == '0);
  assign full           = (count == FULL_CNT);
  assign do_push        = push && !full;
  assign do_pop         = pop && !empty;
  assign overflow_pulse = push && full;
  assign head           = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus MMIO cycle counter, status/clear and a host-drained output FIFO.
// Latency: reads combinational, writes commit at the edge. Backpressure: host out_ready; FIFO overflow is sticky.
// RAM contents survive reset; counter, FIFO and error stickies do not.
module dmem_responder
  import mips_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_data_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_sticky
);

  localparam int RW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram [RAM_WORDS];
  logic [RW-1:0]  ram_idx;
  mmio_sel_t      sel;
  logic           aligned;
  logic           wr_ok;
  logic           ram_we;
  logic           fifo_push;
  logic           clr_wr;
  logic           misalign_evt;
  logic [31:0]    cycle_cnt;
  logic           overflow;
  logic           misalign;
  logic [31:0]    status;

  logic           fifo_empty;
  logic           fifo_full;
  logic [CW-1:0]  fifo_count;
  logic           fifo_ovf;

  assign sel          = decode_sel(mem_data_addr, MMIO_BASE[31:16]);
  assign ram_idx      = mem_data_addr[RW+1:2];
  assign aligned      = (mem_data_addr[1:0] == 2'b00);
  assign wr_ok        = mem_we && aligned && !rst;
  assign ram_we       = wr_ok && (sel == SEL_RAM);
  assign fifo_push    = wr_ok && (sel == SEL_FIFO);
  assign clr_wr       = wr_ok && (sel == SEL_CLR);
  assign misalign_evt = mem_we && !aligned;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (fifo_push),
    .push_data      (mem_write_data),
    .pop            (out_valid && out_ready),
    .head           (out_data),
    .empty          (fifo_empty),
    .full           (fifo_full),
    .count          (fifo_count),
    .overflow_pulse (fifo_ovf)
  );

  assign out_valid  = !fifo_empty;
  assign err_sticky = overflow || misalign;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= mem_write_data;
  end

  // A new error event in the clear cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      overflow  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      overflow  <= fifo_ovf | (overflow & ~(clr_wr & mem_write_data[ST_OVERFLOW]));
      misalign  <= misalign_evt | (misalign & ~(clr_wr & mem_write_data[ST_MISALIGN]));
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_FULL]                = fifo_full;
    status[ST_OVERFLOW]            = overflow;
    status[ST_MISALIGN]            = misalign;
    status[ST_COUNT_LSB +: CW]     = fifo_count;
  end

  always_comb begin
    mem_read_data = '0;
    case (sel)
      SEL_RAM:    mem_read_data = ram[ram_idx];
      SEL_CYCLE:  mem_read_data = cycle_cnt;
      SEL_STATUS: mem_read_data = status;
      default:    ;
    endcase
  end

endmodule
